// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick timer arbiter: FSM state encodings and default tick period.
// Latency: none (constants only).
// Backpressure: not applicable.
package tick_timer_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // clk cycles per tick in the production build
  localparam int CLOCK_CYCLE_DEFAULT = 50000000;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-cycle divider producing a one-cycle tick every CLOCK_CYCLE enabled cycles.
// Latency: tick on the CLOCK_CYCLE-th enabled cycle after a clear.
// Backpressure: none; en simply freezes the count, clr forces it to zero.
module tick_prescaler #(
  parameter int CLOCK_CYCLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLOCK_CYCLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCK_CYCLE - 1);

  logic [CNT_W-1:0] count;

  assign tick = en && (count == CNT_MAX);

  // count 0..CLOCK_CYCLE-1 while enabled; clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == CNT_MAX) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/tick_timer_arbiter.sv
// One shared tick prescaler, granted round-robin to N_REQ requesters; counts dur ticks then pulses done.
// Latency: grant 1 cycle after req is seen in IDLE; done dur*CLOCK_CYCLE cycles after grant; grant drops next.
// Backpressure: req is a held level; owner is never revoked. TIMER_ABORT_EN adds abort/aborted.
module tick_timer_arbiter
  import tick_timer_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DUR_W       = 8,
  parameter int CLOCK_CYCLE = CLOCK_CYCLE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   tick_o
`ifdef TIMER_ABORT_EN
  ,
  input  logic                   abort,
  output logic                   aborted
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [1:0]       state;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  logic [DUR_W-1:0] remaining;
  logic [PTR_W-1:0] pick;
  logic [DUR_W-1:0] pick_dur;
  logic             tick;
  logic             abort_i;

  // First set request at or after the pointer, wrapping; only meaningful when |r.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] sel;
    logic             found;
    int               idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && r[idx]) begin
        sel   = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

`ifdef TIMER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // round-robin selection and the candidate's duration, used only in IDLE
  always_comb begin
    pick     = rr_pick(req, rr_ptr);
    pick_dur = dur[int'(pick)*DUR_W +: DUR_W];
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE) ? grant : '0;
  assign tick_o = tick;

  // prescaler runs only while timing; it is held at zero otherwise so each grant starts fresh
  tick_prescaler #(
    .CLOCK_CYCLE (CLOCK_CYCLE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != ST_RUN),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  // arbitration and countdown FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            owner     <= pick;
            remaining <= pick_dur;
            state     <= (pick_dur == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state <= ST_DONE;
          end else if (tick) begin
            // remaining is >= 1 here, so the decrement cannot wrap
            remaining <= remaining - 1'b1;
            if (remaining == DUR_W'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          grant  <= '0;
          // last owner drops to lowest priority
          rr_ptr <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef TIMER_ABORT_EN
  // flags a done that was cut short; set on entry to DONE via abort, cleared on leaving DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted <= 1'b0;
    end else if (state == ST_RUN && abort_i) begin
      aborted <= 1'b1;
    end else if (state == ST_DONE) begin
      aborted <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Directed bench for tick_timer_arbiter with CLOCK_CYCLE=4, N_REQ=4, DUR_W=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Abort checks are compiled only when TIMER_ABORT_EN is defined.
module tb_tick_timer_arbiter;

  localparam int N_REQ       = 4;
  localparam int DUR_W       = 8;
  localparam int CLOCK_CYCLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] dur;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        tick_o;
`ifdef TIMER_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tick_timer_arbiter #(
    .N_REQ       (N_REQ),
    .DUR_W       (DUR_W),
    .CLOCK_CYCLE (CLOCK_CYCLE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .dur    (dur),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .tick_o (tick_o)
`ifdef TIMER_ABORT_EN
    ,
    .abort  (abort),
    .aborted(aborted)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    while (grant == 4'b0000 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 32'(grant), 32'(exp));
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp);
    int n = 0;
    while (done == 4'b0000 && n < 2000) begin
      step();
      n++;
    end
    chk(tag, 32'(done), 32'(exp));
  endtask

  initial begin
    logic       tick_exp;
    logic [3:0] gexp;
    logic [3:0] dexp;
    int         ticks;
    int         n;

    // ---- reset state ----
    rst = 1'b1;
    req = 4'b0000;
    dur = 32'h0;
`ifdef TIMER_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tick", 32'(tick_o), 32'h0);
`ifdef TIMER_ABORT_EN
    chk("rst_aborted", 32'(aborted), 32'h0);
`endif
    rst = 1'b0;
    step();

    // ---- ch1, dur=3: ticks at t+4,8,12, done t+13, grant drops t+14 ----
    req = 4'b0010;
    dur = 32'h0000_0300;
    for (int k = 1; k <= 14; k++) begin
      step();
      tick_exp = (k == 4) || (k == 8) || (k == 12);
      gexp     = (k <= 13) ? 4'b0010 : 4'b0000;
      dexp     = (k == 13) ? 4'b0010 : 4'b0000;
      chk($sformatf("t1_tick_c%0d", k), 32'(tick_o), 32'(tick_exp));
      chk($sformatf("t1_grant_c%0d", k), 32'(grant), 32'(gexp));
      chk($sformatf("t1_done_c%0d", k), 32'(done), 32'(dexp));
      if (k == 1) chk("t1_busy", 32'(busy), 32'h1);
      if (k == 13) req = 4'b0000;
    end
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // ---- round robin from reset: 0,1,2,3 then req=0101 -> 0,2 ----
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    dur = 32'h0101_0101;
    wait_grant("t2_grant_ch0", 4'b0001);
    wait_done("t2_done_ch0", 4'b0001);
    step();
    chk("t2_gap0_grant", 32'(grant), 32'h0);
    chk("t2_gap0_busy", 32'(busy), 32'h0);
    wait_grant("t2_grant_ch1", 4'b0010);
    wait_done("t2_done_ch1", 4'b0010);
    step();
    wait_grant("t2_grant_ch2", 4'b0100);
    wait_done("t2_done_ch2", 4'b0100);
    step();
    wait_grant("t2_grant_ch3", 4'b1000);
    req = 4'b0101;
    wait_done("t2_done_ch3", 4'b1000);
    step();
    chk("t2_gap3_grant", 32'(grant), 32'h0);
    wait_grant("t2_regrant_ch0", 4'b0001);
    wait_done("t2_redone_ch0", 4'b0001);
    step();
    wait_grant("t2_regrant_ch2", 4'b0100);
    req = 4'b0000;
    wait_done("t2_redone_ch2", 4'b0100);
    step();
    chk("t2_end_grant", 32'(grant), 32'h0);

    // ---- zero duration: grant and done together at t+1, no ticks ----
    req = 4'b0100;
    dur = 32'h0;
    step();
    chk("t3_grant", 32'(grant), 32'h4);
    chk("t3_done", 32'(done), 32'h4);
    chk("t3_busy", 32'(busy), 32'h1);
    req = 4'b0000;
    ticks = (tick_o === 1'b1) ? 1 : 0;
    step();
    chk("t3_after_grant", 32'(grant), 32'h0);
    chk("t3_after_done", 32'(done), 32'h0);
    for (int k = 0; k < 6; k++) begin
      if (tick_o === 1'b1) ticks++;
      step();
    end
    chk("t3_no_ticks", 32'(ticks), 32'h0);

    // ---- reset mid-RUN of ch3: clean idle next cycle, then ch0 first ----
    req = 4'b1000;
    dur = 32'h0A00_0000;
    wait_grant("t4_grant_ch3", 4'b1000);
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1001;
    dur = 32'h0100_0001;
    chk("t4_rst_grant", 32'(grant), 32'h0);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    chk("t4_rst_done", 32'(done), 32'h0);
    chk("t4_rst_tick", 32'(tick_o), 32'h0);
    step();
    chk("t4_first_ch0", 32'(grant), 32'h1);
    wait_done("t4_done_ch0", 4'b0001);
    step();
    wait_grant("t4_then_ch3", 4'b1000);
    req = 4'b0000;
    wait_done("t4_done_ch3", 4'b1000);
    step();

    // ---- dur=255: exactly 255 ticks, done 255*4 cycles after grant ----
    req = 4'b0001;
    dur = 32'h0000_00FF;
    step();
    chk("t5_grant", 32'(grant), 32'h1);
    ticks = 0;
    n = 0;
    while (done == 4'b0000 && n < 1100) begin
      step();
      n++;
      if (tick_o === 1'b1) ticks++;
    end
    chk("t5_ticks", 32'(ticks), 32'd255);
    chk("t5_done_cycle", 32'(n), 32'd1020);
    chk("t5_done", 32'(done), 32'h1);
`ifdef TIMER_ABORT_EN
    chk("t5_not_aborted", 32'(aborted), 32'h0);
`endif
    req = 4'b0000;
    step();
    chk("t5_after_grant", 32'(grant), 32'h0);
    chk("t5_after_tick", 32'(tick_o), 32'h0);

`ifdef TIMER_ABORT_EN
    // ---- abort one cycle after the 2nd tick of a dur=5 timing ----
    req = 4'b0001;
    dur = 32'h0000_0005;
    step();
    chk("t6_grant", 32'(grant), 32'h1);
    ticks = 0;
    n = 0;
    while (ticks < 2 && n < 40) begin
      step();
      n++;
      if (tick_o === 1'b1) ticks++;
    end
    chk("t6_two_ticks", 32'(ticks), 32'd2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    req = 4'b0000;
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_aborted", 32'(aborted), 32'h1);
    ticks = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (tick_o === 1'b1) ticks++;
    end
    chk("t6_no_more_ticks", 32'(ticks), 32'h0);
    chk("t6_idle_grant", 32'(grant), 32'h0);
    chk("t6_aborted_clear", 32'(aborted), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
